// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: round-robin arbiter sharing one classic Wishbone RAM slave
// between NR_MASTERS bus masters. The grant is held until the owner drops cyc.
// A per-access watchdog terminates hung strobes with err.
module wb_ram_arbiter #(
   parameter int unsigned NR_MASTERS = 2,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [32*NR_MASTERS-1:0]   m_adr_i,
   input  logic [32*NR_MASTERS-1:0]   m_dat_i,
   input  logic [4*NR_MASTERS-1:0]    m_sel_i,
   input  logic [NR_MASTERS-1:0]      m_we_i,
   input  logic [NR_MASTERS-1:0]      m_cyc_i,
   input  logic [NR_MASTERS-1:0]      m_stb_i,
   output logic [31:0]                m_dat_o,
   output logic [NR_MASTERS-1:0]      m_ack_o,
   output logic [NR_MASTERS-1:0]      m_err_o,
   output logic [31:0]                s_adr_o,
   output logic [31:0]                s_dat_o,
   output logic [3:0]                 s_sel_o,
   output logic                       s_we_o,
   output logic                       s_cyc_o,
   output logic                       s_stb_o,
   input  logic [31:0]                s_dat_i,
   input  logic                       s_ack_i,
   input  logic                       s_err_i,
   output logic [NR_MASTERS-1:0]      grant_o,
   output logic                       timeout_o
);

   localparam int unsigned IW = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;
   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] WD_MAX   = CW'(TIMEOUT);
   localparam logic [IW-1:0] LAST_RST = IW'(NR_MASTERS - 1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [NR_MASTERS-1:0]   grant;
   logic [NR_MASTERS-1:0]   grant_next;
   logic [IW-1:0]           last;
   logic [IW-1:0]           last_next;
   logic [IW-1:0]           cand;
   logic [IW-1:0]           win_idx;
   logic                    win_found;
   logic [CW-1:0]           wd_cnt;
   logic                    own_cyc;
   logic                    own_stb;
   logic                    wd_fire;
   logic                    wd_kill;

   // Owner handshake: grant is zero outside BUSY, so these are low when idle.
   always_comb begin
      own_cyc = |(grant & m_cyc_i);
      own_stb = |(grant & m_stb_i);
   end

   // Round-robin pick: first requester scanning from last+1 modulo NR_MASTERS.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned k = 1; k <= NR_MASTERS; k++) begin
         cand = IW'((32'(last) + k) % NR_MASTERS);
         if (!win_found && m_cyc_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Next-state logic: grant on any request in IDLE, release when owner drops cyc.
   always_comb begin
      state_next = state;
      grant_next = grant;
      last_next  = last;
      case (state)
         IDLE: begin
            if (win_found) begin
               state_next = BUSY;
               grant_next = NR_MASTERS'(1) << win_idx;
               last_next  = win_idx;
            end
         end
         BUSY: begin
            if (!own_cyc) begin
               state_next = IDLE;
               grant_next = '0;
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase
   end

   // State, grant and round-robin pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         last  <= LAST_RST;
      end else begin
         state <= state_next;
         grant <= grant_next;
         last  <= last_next;
      end
   end

   // Watchdog fires when a strobe has waited TIMEOUT cycles with no response;
   // a same-cycle slave ack/err takes priority and suppresses the fire.
   always_comb begin
      wd_fire = (TIMEOUT != 0) && (wd_cnt == WD_MAX) && own_stb && !s_ack_i && !s_err_i;
      wd_kill = wd_fire;
   end

   // Watchdog counter: counts strobed cycles without response, saturating.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (state != BUSY || !own_stb || s_ack_i || s_err_i || wd_fire) begin
         wd_cnt <= '0;
      end else if (wd_cnt != WD_MAX) begin
         wd_cnt <= wd_cnt + CW'(1);
      end
   end

   // Slave-side mux from the one-hot owner plus response routing back to it.
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      for (int unsigned i = 0; i < NR_MASTERS; i++) begin
         if (grant[i]) begin
            s_adr_o = m_adr_i[32*i +: 32];
            s_dat_o = m_dat_i[32*i +: 32];
            s_sel_o = m_sel_i[4*i +: 4];
            s_we_o  = m_we_i[i];
         end
      end
      s_cyc_o   = own_cyc & ~wd_kill;
      s_stb_o   = own_stb & ~wd_kill;
      m_ack_o   = grant & {NR_MASTERS{s_ack_i}};
      m_err_o   = grant & {NR_MASTERS{s_err_i | wd_fire}};
      m_dat_o   = s_dat_i;
      grant_o   = grant;
      timeout_o = wd_fire;
   end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed self-checking bench for wb_ram_arbiter with two masters and a
// small RAM slave model that acks in its 2nd strobed cycle (or on demand).
module tb_wb_ram_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [63:0] m_adr;
   logic [63:0] m_dat;
   logic [7:0]  m_sel;
   logic [1:0]  m_we;
   logic [1:0]  m_cyc;
   logic [1:0]  m_stb;

   logic [31:0] m_dat_o;
   logic [1:0]  m_ack_o;
   logic [1:0]  m_err_o;
   logic [31:0] s_adr_o;
   logic [31:0] s_dat_o;
   logic [3:0]  s_sel_o;
   logic        s_we_o;
   logic        s_cyc_o;
   logic        s_stb_o;
   logic [31:0] s_dat_i;
   logic        s_ack_i;
   logic        s_err_i;
   logic [1:0]  grant_o;
   logic        timeout_o;

   // second instance with the watchdog disabled; its slave never responds
   logic [31:0] z_m_dat_o;
   logic [1:0]  z_m_ack_o;
   logic [1:0]  z_m_err_o;
   logic [31:0] z_s_adr_o;
   logic [31:0] z_s_dat_o;
   logic [3:0]  z_s_sel_o;
   logic        z_s_we_o;
   logic        z_s_cyc_o;
   logic        z_s_stb_o;
   logic [31:0] z_s_dat_i;
   logic        z_s_ack_i;
   logic        z_s_err_i;
   logic [1:0]  z_grant_o;
   logic        z_timeout_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic        auto_ack;
   logic        force_ack;
   logic        ws;
   logic [31:0] mem [256];

   wb_ram_arbiter #(.NR_MASTERS(2), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
      .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
      .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   wb_ram_arbiter #(.NR_MASTERS(2), .TIMEOUT(0)) dut0 (
      .clk(clk), .rst(rst),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
      .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
      .m_dat_o(z_m_dat_o), .m_ack_o(z_m_ack_o), .m_err_o(z_m_err_o),
      .s_adr_o(z_s_adr_o), .s_dat_o(z_s_dat_o), .s_sel_o(z_s_sel_o),
      .s_we_o(z_s_we_o), .s_cyc_o(z_s_cyc_o), .s_stb_o(z_s_stb_o),
      .s_dat_i(z_s_dat_i), .s_ack_i(z_s_ack_i), .s_err_i(z_s_err_i),
      .grant_o(z_grant_o), .timeout_o(z_timeout_o)
   );

   assign z_s_dat_i = 32'h0;
   assign z_s_ack_i = 1'b0;
   assign z_s_err_i = 1'b0;

   // RAM slave model: ws marks a strobe already seen, so ack lands on the 2nd strobed cycle.
   always_ff @(posedge clk) begin
      if (rst) ws <= 1'b0;
      else     ws <= s_cyc_o && s_stb_o && !s_ack_i;
      if (s_cyc_o && s_stb_o && s_ack_i && s_we_o) mem[s_adr_o[9:2]] <= s_dat_o;
   end

   assign s_ack_i = auto_ack ? ws : force_ack;
   assign s_err_i = 1'b0;
   assign s_dat_i = (s_adr_o == 32'h100) ? 32'hDEADBEEF : mem[s_adr_o[9:2]];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
      m_cyc[i]          = cyc;
      m_stb[i]          = stb;
      m_we[i]           = we;
      m_adr[32*i +: 32] = adr;
      m_dat[32*i +: 32] = dat;
      m_sel[4*i +: 4]   = 4'hF;
   endtask

   task automatic clear_masters;
      m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      clear_masters();
      auto_ack  = 1'b1;
      force_ack = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      auto_ack = 1'b1; force_ack = 1'b0;
      clear_masters();
      m_cyc = 2'b11; m_stb = 2'b11;
      tick(); tick();
      total_cnt++; if (grant_o !== 2'b00) $display("FAIL reset_grant got %b want 00", grant_o); else pass_cnt++;
      total_cnt++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) $display("FAIL reset_cyc_stb got %b%b want 00", s_cyc_o, s_stb_o); else pass_cnt++;
      total_cnt++; if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) $display("FAIL reset_ack_err got %b/%b want 00/00", m_ack_o, m_err_o); else pass_cnt++;
      total_cnt++; if (timeout_o !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout_o); else pass_cnt++;
      total_cnt++; if (s_adr_o !== 32'h0 || s_we_o !== 1'b0 || s_sel_o !== 4'h0) $display("FAIL reset_slave_bus got adr=%h we=%b sel=%h want 0", s_adr_o, s_we_o, s_sel_o); else pass_cnt++;
      clear_masters();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single;
      do_reset();
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
      #1;
      total_cnt++; if (grant_o !== 2'b00) $display("FAIL single_pre_grant got %b want 00", grant_o); else pass_cnt++;
      tick();
      total_cnt++; if (grant_o !== 2'b10) $display("FAIL single_grant got %b want 10", grant_o); else pass_cnt++;
      total_cnt++; if (s_adr_o !== 32'h100 || s_stb_o !== 1'b1 || s_cyc_o !== 1'b1) $display("FAIL single_slave got adr=%h stb=%b cyc=%b want 100/1/1", s_adr_o, s_stb_o, s_cyc_o); else pass_cnt++;
      total_cnt++; if (m_ack_o !== 2'b00) $display("FAIL single_early_ack got %b want 00", m_ack_o); else pass_cnt++;
      tick();
      total_cnt++; if (m_ack_o !== 2'b10) $display("FAIL single_ack got %b want 10", m_ack_o); else pass_cnt++;
      total_cnt++; if (m_dat_o !== 32'hDEADBEEF) $display("FAIL single_rdata got %h want deadbeef", m_dat_o); else pass_cnt++;
      tick();
      set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      total_cnt++; if (m_ack_o !== 2'b00 || grant_o !== 2'b10) $display("FAIL single_drop got ack=%b grant=%b want 00/10", m_ack_o, grant_o); else pass_cnt++;
      tick();
      total_cnt++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) $display("FAIL single_idle got grant=%b cyc=%b want 00/0", grant_o, s_cyc_o); else pass_cnt++;
   endtask

   task automatic test_round_robin;
      int own;
      logic [1:0] exp_g;
      do_reset();
      set_m(0, 1'b1, 1'b1, 1'b1, 32'h20, 32'hA000_0000);
      set_m(1, 1'b1, 1'b1, 1'b1, 32'h24, 32'hA000_0001);
      for (int g = 0; g < 4; g++) begin
         own   = g % 2;
         exp_g = (own == 0) ? 2'b01 : 2'b10;
         tick();
         total_cnt++; if (grant_o !== exp_g) $display("FAIL rr_grant%0d got %b want %b", g, grant_o, exp_g); else pass_cnt++;
         total_cnt++; if (s_adr_o !== 32'h20 + 32'(4*own)) $display("FAIL rr_adr%0d got %h want %h", g, s_adr_o, 32'h20 + 32'(4*own)); else pass_cnt++;
         tick();
         total_cnt++; if (m_ack_o !== exp_g) $display("FAIL rr_ack%0d got %b want %b", g, m_ack_o, exp_g); else pass_cnt++;
         tick();
         set_m(own, 1'b0, 1'b0, 1'b1, 32'h20 + 32'(4*own), 32'hA000_0000 + 32'(own));
         #1;
         total_cnt++; if (s_cyc_o !== 1'b0) $display("FAIL rr_release%0d got cyc=%b want 0", g, s_cyc_o); else pass_cnt++;
         tick();
         total_cnt++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) $display("FAIL rr_dead%0d got grant=%b cyc=%b want 00/0", g, grant_o, s_cyc_o); else pass_cnt++;
         set_m(own, 1'b1, 1'b1, 1'b1, 32'h20 + 32'(4*own), 32'hA000_0000 + 32'(own));
      end
      clear_masters();
   endtask

   task automatic test_grant_held;
      logic [31:0] d [4];
      d[0] = 32'h1111_0000; d[1] = 32'h2222_0001; d[2] = 32'h3333_0002; d[3] = 32'h4444_0003;
      do_reset();
      set_m(1, 1'b1, 1'b1, 1'b1, 32'h200, 32'h55);
      set_m(0, 1'b1, 1'b1, 1'b1, 32'h0, d[0]);
      tick();
      for (int w = 0; w < 4; w++) begin
         total_cnt++; if (grant_o !== 2'b01) $display("FAIL held_grant%0d got %b want 01", w, grant_o); else pass_cnt++;
         tick();
         total_cnt++; if (m_ack_o !== 2'b01) $display("FAIL held_ack%0d got %b want 01", w, m_ack_o); else pass_cnt++;
         tick();
         if (w < 3) set_m(0, 1'b1, 1'b1, 1'b1, 32'(4*(w+1)), d[w+1]);
         else       set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         #1;
      end
      total_cnt++; if (grant_o !== 2'b01) $display("FAIL held_last got %b want 01", grant_o); else pass_cnt++;
      tick();
      total_cnt++; if (grant_o !== 2'b00) $display("FAIL held_dead got %b want 00", grant_o); else pass_cnt++;
      tick();
      total_cnt++; if (grant_o !== 2'b10) $display("FAIL held_next got %b want 10", grant_o); else pass_cnt++;
      for (int w = 0; w < 4; w++) begin
         total_cnt++; if (mem[w] !== d[w]) $display("FAIL held_ram%0d got %h want %h", w, mem[w], d[w]); else pass_cnt++;
      end
      clear_masters();
   endtask

   task automatic test_watchdog;
      int early;
      int z_fires;
      early = 0;
      z_fires = 0;
      do_reset();
      auto_ack = 1'b0;
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
      tick();
      total_cnt++; if (s_stb_o !== 1'b1) $display("FAIL wd_first_stb got %b want 1", s_stb_o); else pass_cnt++;
      for (int k = 1; k < 8; k++) begin
         tick();
         if (m_err_o !== 2'b00 || timeout_o !== 1'b0) early++;
         if (z_m_err_o !== 2'b00 || z_timeout_o !== 1'b0) z_fires++;
      end
      total_cnt++; if (early !== 0) $display("FAIL wd_early got %0d early fires want 0", early); else pass_cnt++;
      tick();
      total_cnt++; if (timeout_o !== 1'b1) $display("FAIL wd_timeout got %b want 1", timeout_o); else pass_cnt++;
      total_cnt++; if (m_err_o !== 2'b01) $display("FAIL wd_err got %b want 01", m_err_o); else pass_cnt++;
      total_cnt++; if (s_stb_o !== 1'b0 || s_cyc_o !== 1'b0) $display("FAIL wd_kill got stb=%b cyc=%b want 0/0", s_stb_o, s_cyc_o); else pass_cnt++;
      tick();
      total_cnt++; if (timeout_o !== 1'b0 || s_stb_o !== 1'b1) $display("FAIL wd_after got timeout=%b stb=%b want 0/1", timeout_o, s_stb_o); else pass_cnt++;
      for (int k = 0; k < 20; k++) begin
         if (z_m_err_o !== 2'b00 || z_timeout_o !== 1'b0) z_fires++;
         tick();
      end
      total_cnt++; if (z_fires !== 0) $display("FAIL wd_disabled got %0d fires want 0", z_fires); else pass_cnt++;
      clear_masters();
   endtask

   task automatic test_collision_ack;
      do_reset();
      auto_ack = 1'b0;
      force_ack = 1'b0;
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0);
      tick();
      for (int k = 0; k < 8; k++) tick();
      force_ack = 1'b1;
      #1;
      total_cnt++; if (m_ack_o !== 2'b01) $display("FAIL coll_ack got %b want 01", m_ack_o); else pass_cnt++;
      total_cnt++; if (m_err_o !== 2'b00 || timeout_o !== 1'b0) $display("FAIL coll_noerr got err=%b timeout=%b want 00/0", m_err_o, timeout_o); else pass_cnt++;
      total_cnt++; if (s_stb_o !== 1'b1) $display("FAIL coll_stb got %b want 1", s_stb_o); else pass_cnt++;
      tick();
      force_ack = 1'b0;
      clear_masters();
   endtask

   task automatic test_reset_mid;
      do_reset();
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
      tick();
      total_cnt++; if (grant_o !== 2'b10) $display("FAIL rmid_grant got %b want 10", grant_o); else pass_cnt++;
      rst = 1'b1;
      tick();
      total_cnt++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) $display("FAIL rmid_clear got grant=%b cyc=%b stb=%b want 00/0/0", grant_o, s_cyc_o, s_stb_o); else pass_cnt++;
      total_cnt++; if (m_ack_o !== 2'b00) $display("FAIL rmid_noack got %b want 00", m_ack_o); else pass_cnt++;
      rst = 1'b0;
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
      tick();
      total_cnt++; if (grant_o !== 2'b01) $display("FAIL rmid_next got %b want 01", grant_o); else pass_cnt++;
      clear_masters();
      tick();
   endtask

   initial begin
      rst = 1'b1;
      auto_ack = 1'b1;
      force_ack = 1'b0;
      clear_masters();
      test_reset();
      test_single();
      test_round_robin();
      test_grant_held();
      test_watchdog();
      test_collision_ack();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout got no completion want finish");
      $fatal(1, "simulation time limit");
   end

endmodule
